// File: rtl/display_pkg.sv
// Shared constants and types for the memory-mapped display port.
package display_pkg;

  localparam int unsigned BUS_W     = 32;
  localparam int unsigned DISPLAY_W = 8;

  localparam logic [BUS_W-1:0] DISPLAY_ADDR_DEFAULT = 32'h0000_00FC;

  typedef enum logic {
    StLive,
    StFrozen
  } view_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter and
// rising-edge pulse on an accepted press.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            s1_q, s2_q;
  logic            deb_q, deb_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            settle;

  always_comb begin
    deb_d  = deb_q;
    cnt_d  = '0;
    settle = (s2_q != deb_q) && (cnt_q == CntLast);
    // Any cycle where the synchronized level agrees with deb restarts the count.
    if (s2_q != deb_q) begin
      if (settle) begin
        deb_d = s2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign level      = deb_q;
  assign rise_pulse = settle && s2_q;

endmodule

// File: rtl/display_port.sv
// Display output port: captures stores to DISPLAY_ADDR and shows them, with a
// debounced button that freezes the shown value while newer writes wait.
module display_port
  import display_pkg::*;
#(
  parameter logic [BUS_W-1:0] DISPLAY_ADDR    = DISPLAY_ADDR_DEFAULT,
  parameter int unsigned      DEBOUNCE_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_write,
  input  logic [BUS_W-1:0]     addr,
  input  logic [BUS_W-1:0]     write_data,
  input  logic                 btn_freeze,
  output logic [DISPLAY_W-1:0] read_data,
  output logic [BUS_W-1:0]     rd_data,
  output logic                 frozen,
  output logic                 pending
);

  logic                 addr_match, hit;
  logic                 toggle_evt, unfreeze_evt;
  logic                 btn_level;
  logic [DISPLAY_W-1:0] wdata8;
  logic [DISPLAY_W-1:0] shadow_q, shadow_d;
  logic [DISPLAY_W-1:0] shown_q, shown_d;
  logic                 pending_q, pending_d;
  view_state_e          state_q, state_d;
  logic                 unused_bits;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .raw       (btn_freeze),
    .level     (btn_level),
    .rise_pulse(toggle_evt)
  );

  assign addr_match   = (addr == DISPLAY_ADDR);
  assign hit          = mem_write && addr_match;
  assign wdata8       = write_data[DISPLAY_W-1:0];
  assign unfreeze_evt = toggle_evt && (state_q == StFrozen);
  assign unused_bits  = ^{write_data[BUS_W-1:DISPLAY_W], btn_level};

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    shown_d   = shown_q;
    pending_d = pending_q;

    if (toggle_evt) begin
      state_d = (state_q == StFrozen) ? StLive : StFrozen;
    end

    if (hit) begin
      shadow_d = wdata8;
    end

    // A write landing on the unfreeze edge is newer than the shadow, so it wins.
    if (hit && ((state_q == StLive) || unfreeze_evt)) begin
      shown_d = wdata8;
    end else if (unfreeze_evt) begin
      shown_d = shadow_q;
    end

    if (unfreeze_evt) begin
      pending_d = 1'b0;
    end else if (hit && (state_q == StFrozen)) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StLive;
      shadow_q  <= '0;
      shown_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      shown_q   <= shown_d;
      pending_q <= pending_d;
    end
  end

  assign read_data = shown_q;
  assign frozen    = (state_q == StFrozen);
  assign pending   = pending_q;
  assign rd_data   = addr_match ? {{(BUS_W - DISPLAY_W){1'b0}}, shadow_q} : '0;

endmodule

// File: tb/tb_display_port.sv
// Self-checking bench for display_port with a behavioural model of the
// display/freeze rules and a sliding-window model of the debouncer.
module tb_display_port;

  localparam int unsigned D = 4;
  localparam logic [31:0] ADDR = 32'h0000_00FC;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        btn_freeze;
  logic [7:0]  read_data;
  logic [31:0] rd_data;
  logic        frozen;
  logic        pending;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] m_shadow, m_shown;
  logic       m_frozen, m_pending, m_deb;
  bit         raw_hist[$];
  bit         s2_hist[$];

  display_port #(
    .DISPLAY_ADDR   (ADDR),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_write (mem_write),
    .addr      (addr),
    .write_data(write_data),
    .btn_freeze(btn_freeze),
    .read_data (read_data),
    .rd_data   (rd_data),
    .frozen    (frozen),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_rd();
    return (addr == ADDR) ? {24'h0, m_shadow} : 32'h0;
  endfunction

  // Advance one clock edge, updating the model from the pre-edge inputs.
  task automatic tick();
    bit s2, flip, tog, hit, unf;
    logic [7:0] wd8;
    if (reset) begin
      m_shadow = 8'h00; m_shown = 8'h00;
      m_frozen = 1'b0; m_pending = 1'b0; m_deb = 1'b0;
      raw_hist = {};
      raw_hist.push_back(1'b0);
      raw_hist.push_back(1'b0);
      s2_hist = {};
    end else begin
      // Synchronized level seen by the debouncer lags the raw input by two edges.
      s2 = raw_hist[raw_hist.size() - 2];
      raw_hist.push_back(btn_freeze);
      while (raw_hist.size() > 4) void'(raw_hist.pop_front());
      s2_hist.push_back(s2);
      while (s2_hist.size() > D) void'(s2_hist.pop_front());
      flip = (s2_hist.size() == D);
      foreach (s2_hist[i]) if (s2_hist[i] == m_deb) flip = 1'b0;
      tog = flip && s2;
      if (flip) m_deb = s2;
      wd8 = write_data[7:0];
      hit = mem_write && (addr == ADDR);
      unf = tog && m_frozen;
      if (hit && (!m_frozen || unf)) m_shown = wd8;
      else if (unf) m_shown = m_shadow;
      if (unf) m_pending = 1'b0;
      else if (hit && m_frozen) m_pending = 1'b1;
      if (hit) m_shadow = wd8;
      m_frozen = m_frozen ^ tog;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_write = 1'b0; addr = ADDR; write_data = 32'h0; btn_freeze = 1'b0;
    ticks(2);
    reset = 1'b0;
    tick();
    checks++; if (read_data !== 8'h00) begin failures++;
      $display("FAIL reset_read_data got=%h want=00", read_data); end
    checks++; if (frozen !== 1'b0) begin failures++;
      $display("FAIL reset_frozen got=%b want=0", frozen); end
    checks++; if (pending !== 1'b0) begin failures++;
      $display("FAIL reset_pending got=%b want=0", pending); end
    checks++; if (rd_data !== 32'h0) begin failures++;
      $display("FAIL reset_rd_data got=%h want=00000000", rd_data); end
  endtask

  task automatic test_store();
    mem_write = 1'b1; addr = ADDR; write_data = 32'h1234_00A5;
    tick();
    mem_write = 1'b0;
    checks++; if (read_data !== 8'hA5) begin failures++;
      $display("FAIL store_read_data got=%h want=a5", read_data); end
    checks++; if (rd_data !== 32'h0000_00A5) begin failures++;
      $display("FAIL store_rd_data got=%h want=000000a5", rd_data); end
    mem_write = 1'b1; addr = 32'h0000_00F8; write_data = 32'h0000_0033;
    tick();
    mem_write = 1'b0;
    checks++; if (read_data !== 8'hA5) begin failures++;
      $display("FAIL store_other_addr got=%h want=a5", read_data); end
    checks++; if (rd_data !== 32'h0) begin failures++;
      $display("FAIL store_other_rd got=%h want=00000000", rd_data); end
    addr = ADDR; #1;
    checks++; if (rd_data !== 32'h0000_00A5) begin failures++;
      $display("FAIL store_shadow_kept got=%h want=000000a5", rd_data); end
  endtask

  task automatic test_freeze_hold();
    btn_freeze = 1'b1;
    ticks(D + 1);
    checks++; if (frozen !== 1'b0) begin failures++;
      $display("FAIL freeze_early got=%b want=0", frozen); end
    tick();
    checks++; if (frozen !== 1'b1) begin failures++;
      $display("FAIL freeze_6th_edge got=%b want=1", frozen); end
    mem_write = 1'b1; addr = ADDR; write_data = 32'h0000_0042;
    tick();
    mem_write = 1'b0;
    checks++; if (read_data !== 8'hA5) begin failures++;
      $display("FAIL freeze_hold got=%h want=a5", read_data); end
    checks++; if (pending !== 1'b1) begin failures++;
      $display("FAIL freeze_pending got=%b want=1", pending); end
    checks++; if (rd_data !== 32'h42) begin failures++;
      $display("FAIL freeze_rd_data got=%h want=00000042", rd_data); end
  endtask

  task automatic press_cycle();
    btn_freeze = 1'b0;
    ticks(D + 4);
    btn_freeze = 1'b1;
    ticks(D + 1);
  endtask

  task automatic test_unfreeze();
    press_cycle();
    checks++; if (frozen !== 1'b1) begin failures++;
      $display("FAIL unfreeze_early got=%b want=1", frozen); end
    tick();
    checks++; if (frozen !== 1'b0) begin failures++;
      $display("FAIL unfreeze_frozen got=%b want=0", frozen); end
    checks++; if (read_data !== 8'h42) begin failures++;
      $display("FAIL unfreeze_shadow got=%h want=42", read_data); end
    checks++; if (pending !== 1'b0) begin failures++;
      $display("FAIL unfreeze_pending got=%b want=0", pending); end
    // Refreeze, park a write, then unfreeze with a simultaneous newer write.
    press_cycle(); tick();
    mem_write = 1'b1; write_data = 32'h0000_0055; tick(); mem_write = 1'b0;
    checks++; if (read_data !== 8'h42 || pending !== 1'b1) begin failures++;
      $display("FAIL refreeze_hold got=%h/%b want=42/1", read_data, pending); end
    press_cycle();
    mem_write = 1'b1; write_data = 32'h0000_0077; tick(); mem_write = 1'b0;
    checks++; if (read_data !== 8'h77) begin failures++;
      $display("FAIL unfreeze_newest got=%h want=77", read_data); end
    checks++; if (frozen !== 1'b0 || pending !== 1'b0) begin failures++;
      $display("FAIL unfreeze_newest_flags got=%b/%b want=0/0", frozen, pending); end
  endtask

  task automatic test_glitch();
    btn_freeze = 1'b0;
    ticks(D + 4);
    btn_freeze = 1'b1; ticks(3);
    btn_freeze = 1'b0; ticks(10);
    checks++; if (frozen !== 1'b0) begin failures++;
      $display("FAIL glitch_frozen got=%b want=0", frozen); end
    checks++; if (dut.u_debounce.deb_q !== 1'b0 || m_deb !== 1'b0) begin failures++;
      $display("FAIL glitch_deb got=%b want=0", dut.u_debounce.deb_q); end
  endtask

  task automatic test_reset_mid();
    btn_freeze = 1'b1; ticks(D + 2);
    mem_write = 1'b1; addr = ADDR; write_data = 32'h0000_00C3; tick(); mem_write = 1'b0;
    btn_freeze = 1'b0; ticks(4);
    checks++; if (frozen !== 1'b1 || pending !== 1'b1) begin failures++;
      $display("FAIL resetmid_setup got=%b/%b want=1/1", frozen, pending); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (read_data !== 8'h00 || frozen !== 1'b0 || pending !== 1'b0 ||
                  rd_data !== 32'h0) begin failures++;
      $display("FAIL resetmid_outputs got=%h/%b/%b/%h want=00/0/0/00000000",
               read_data, frozen, pending, rd_data); end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        btn_freeze = $urandom_range(0, 1);
        hold = $urandom_range(1, 12);
      end
      hold--;
      mem_write  = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0, 1: addr = ADDR;
        2:    addr = 32'h0000_00F8;
        default: addr = ADDR | (32'h1 << $urandom_range(8, 31));
      endcase
      write_data = $urandom;
      reset = ($urandom_range(0, 199) == 0);
      tick();
      checks++; if (read_data !== m_shown) begin failures++;
        $display("FAIL rand_read_data cyc=%0d got=%h want=%h", c, read_data, m_shown); end
      checks++; if (frozen !== m_frozen) begin failures++;
        $display("FAIL rand_frozen cyc=%0d got=%b want=%b", c, frozen, m_frozen); end
      checks++; if (pending !== m_pending) begin failures++;
        $display("FAIL rand_pending cyc=%0d got=%b want=%b", c, pending, m_pending); end
      checks++; if (rd_data !== exp_rd()) begin failures++;
        $display("FAIL rand_rd_data cyc=%0d got=%h want=%h", c, rd_data, exp_rd()); end
    end
    reset = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    test_reset();
    test_store();
    test_freeze_hold();
    test_unfreeze();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
